// File: rtl/alarm_pio_poller.sv
// Avalon-MM read master that polls a one-bit PIO and debounces it into a level plus rise/fall pulses.
// Optional macro ALARM_POLL_IRQ_EN adds a sticky irq flag set on each rise and cleared by irq_ack.
module alarm_pio_poller #(
  parameter int unsigned POLL_INTERVAL    = 1000,
  parameter int unsigned READ_LATENCY     = 1,
  parameter int unsigned DEBOUNCE_SAMPLES = 3,
  parameter logic [1:0]  PIO_ADDR         = 2'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        alarm_level,
  output logic        alarm_rise,
  output logic        alarm_fall,
`ifdef ALARM_POLL_IRQ_EN
  output logic        irq,
  input  logic        irq_ack,
`endif
  output logic        poll_done
);

  localparam int unsigned IW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [IW-1:0] INTV_RELOAD = IW'(POLL_INTERVAL - 1);
  localparam logic [3:0]    LAT_RELOAD  = 4'(READ_LATENCY - 1);
  localparam logic [7:0]    DS          = 8'(DEBOUNCE_SAMPLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] intv_q, intv_d;
  logic [3:0]    lat_q, lat_d;
  logic          read_q, read_d;
  logic [1:0]    addr_q, addr_d;
  logic          done_q, done_d;
  logic          cand_q, cand_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          sample_en;
  logic          sample;
  logic          unused_rd;

  assign sample    = avm_readdata[0];
  assign unused_rd = ^avm_readdata[31:1];

  always_comb begin
    state_d   = state_q;
    intv_d    = intv_q;
    lat_d     = lat_q;
    read_d    = read_q;
    addr_d    = addr_q;
    done_d    = 1'b0;
    sample_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!enable) begin
          intv_d = INTV_RELOAD;
        end else if (intv_q == '0) begin
          state_d = ST_REQ;
          intv_d  = INTV_RELOAD;
          read_d  = 1'b1;
          addr_d  = PIO_ADDR;
        end else begin
          intv_d = intv_q - IW'(1);
        end
      end
      ST_REQ: begin
        if (!avm_waitrequest) begin
          state_d = ST_WAIT;
          read_d  = 1'b0;
          addr_d  = '0;
          lat_d   = LAT_RELOAD;
        end
      end
      ST_WAIT: begin
        if (lat_q == '0) begin
          sample_en = 1'b1;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        read_d  = 1'b0;
        addr_d  = '0;
      end
    endcase
  end

  // Level decision uses the candidate/count values being written on this same edge.
  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sample_en) begin
      if (sample == cand_q) begin
        if (cnt_q != DS) cnt_d = cnt_q + 8'd1;
      end else begin
        cand_d = sample;
        cnt_d  = 8'd1;
      end
      if (cnt_d == DS && cand_d != level_q) begin
        level_d = cand_d;
        rise_d  = cand_d;
        fall_d  = ~cand_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      intv_q  <= INTV_RELOAD;
      lat_q   <= '0;
      read_q  <= 1'b0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      cand_q  <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      intv_q  <= intv_d;
      lat_q   <= lat_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

`ifdef ALARM_POLL_IRQ_EN
  logic irq_q, irq_d;
  // A rise on the same edge as an ack wins, so no event is lost.
  assign irq_d = rise_d | (irq_q & ~irq_ack);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

  assign avm_read    = read_q;
  assign avm_address = addr_q;
  assign poll_done   = done_q;
  assign alarm_level = level_q;
  assign alarm_rise  = rise_q;
  assign alarm_fall  = fall_q;

endmodule

// File: tb/tb_alarm_pio_poller.sv
// Directed bench for alarm_pio_poller: debounce vector table on u0, plus stall, latency, enable and reset sequences.
module tb_alarm_pio_poller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en0, wr0, en1, wr1;
  logic [31:0] rd0, rd1;
  logic [1:0]  addr0, addr1;
  logic        read0, read1, lvl0, lvl1, rise0, rise1, fall0, fall1, done0, done1;
`ifdef ALARM_POLL_IRQ_EN
  logic        irq0, irq1, ack0, ack1;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_rd0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alarm_pio_poller #(
    .POLL_INTERVAL(4), .READ_LATENCY(1), .DEBOUNCE_SAMPLES(3), .PIO_ADDR(2'd0)
  ) u0 (
    .clk(clk), .reset_n(rst_n), .enable(en0),
    .avm_address(addr0), .avm_read(read0), .avm_waitrequest(wr0), .avm_readdata(rd0),
    .alarm_level(lvl0), .alarm_rise(rise0), .alarm_fall(fall0),
`ifdef ALARM_POLL_IRQ_EN
    .irq(irq0), .irq_ack(ack0),
`endif
    .poll_done(done0)
  );

  alarm_pio_poller #(
    .POLL_INTERVAL(2), .READ_LATENCY(3), .DEBOUNCE_SAMPLES(1), .PIO_ADDR(2'd2)
  ) u1 (
    .clk(clk), .reset_n(rst_n), .enable(en1),
    .avm_address(addr1), .avm_read(read1), .avm_waitrequest(wr1), .avm_readdata(rd1),
    .alarm_level(lvl1), .alarm_rise(rise1), .alarm_fall(fall1),
`ifdef ALARM_POLL_IRQ_EN
    .irq(irq1), .irq_ack(ack1),
`endif
    .poll_done(done1)
  );

  typedef struct {
    logic s;
    logic lvl;
    logic rise;
    logic fall;
  } vec_t;

  vec_t vt[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_read(input int sel, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      ok = (sel == 0) ? read0 : read1;
    end
  endtask

  task automatic poll0(input logic s, input logic el, input logic er, input logic ef, input bit chkper);
    bit ok;
    rd0 = $urandom();
    rd0[0] = s;
    wait_read(0, ok);
    chk("poll0_timeout", 32'(ok), 1);
    if (!ok) return;
    if (chkper) chk("poll_period", 32'(cyc - last_rd0), 6);
    last_rd0 = cyc;
    chk("poll0_addr", 32'(addr0), 0);
    @(negedge clk);
    chk("poll0_read_1cyc", 32'(read0), 0);
    chk("poll0_done_early", 32'(done0), 0);
    @(negedge clk);
    chk("poll0_done", 32'(done0), 1);
    chk("poll0_level", 32'(lvl0), 32'(el));
    chk("poll0_rise", 32'(rise0), 32'(er));
    chk("poll0_fall", 32'(fall0), 32'(ef));
    @(negedge clk);
    chk("poll0_rise_1cyc", 32'(rise0), 0);
    chk("poll0_fall_1cyc", 32'(fall0), 0);
    chk("poll0_done_1cyc", 32'(done0), 0);
  endtask

  // Slave of u1 drives the wanted bit only in the cycle before the third edge after acceptance.
  task automatic poll1(input logic want, input logic er, input logic ef, input bit dis);
    bit ok;
    rd1 = $urandom();
    rd1[0] = ~want;
    wait_read(1, ok);
    chk("poll1_timeout", 32'(ok), 1);
    if (!ok) return;
    chk("poll1_addr", 32'(addr1), 2);
    @(negedge clk);
    chk("poll1_read_drop", 32'(read1), 0);
    chk("poll1_addr_idle", 32'(addr1), 0);
    rd1 = $urandom();
    rd1[0] = ~want;
    if (dis) en1 = 1'b0;
    @(negedge clk);
    chk("poll1_done_early", 32'(done1), 0);
    rd1 = $urandom();
    rd1[0] = ~want;
    @(negedge clk);
    chk("poll1_done_early", 32'(done1), 0);
    rd1 = $urandom();
    rd1[0] = want;
    @(negedge clk);
    chk("poll1_done", 32'(done1), 1);
    chk("poll1_level", 32'(lvl1), 32'(want));
    chk("poll1_rise", 32'(rise1), 32'(er));
    chk("poll1_fall", 32'(fall1), 32'(ef));
  endtask

  initial begin
    bit ok;
    int nrd, ndone;
    rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0; rd0 = '0; rd1 = '0;
`ifdef ALARM_POLL_IRQ_EN
    ack0 = 1'b0; ack1 = 1'b0;
`endif
    vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b1, 1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b1, 1'b0, 1'b0, 1'b0};
    vt[13] = '{1'b1, 1'b1, 1'b1, 1'b0};
    vt[14] = '{1'b1, 1'b1, 1'b0, 1'b0};
    vt[15] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vt[16] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vt[17] = '{1'b1, 1'b1, 1'b0, 1'b0};
    vt[18] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vt[19] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vt[20] = '{1'b0, 1'b0, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_read", 32'(read0), 0);
    chk("rst_addr", 32'(addr0), 0);
    chk("rst_level", 32'(lvl0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_pulses", 32'({rise0, fall0}), 0);
`ifdef ALARM_POLL_IRQ_EN
    chk("rst_irq", 32'(irq0), 0);
`endif
    rst_n = 1'b1;
    en0 = 1'b1;

    for (int i = 0; i < 21; i++)
      poll0(vt[i].s, vt[i].lvl, vt[i].rise, vt[i].fall, i > 0);

    // Waitrequest stall: 5 stalled edges, read/address held for 6 cycles.
    rd0 = '0;
    wr0 = 1'b1;
    wait_read(0, ok);
    chk("stall_timeout", 32'(ok), 1);
    for (int i = 0; i < 6; i++) begin
      chk("stall_read", 32'(read0), 1);
      chk("stall_addr", 32'(addr0), 0);
      if (i == 5) wr0 = 1'b0;
      @(negedge clk);
    end
    chk("stall_read_drop", 32'(read0), 0);
    chk("stall_done_early", 32'(done0), 0);
    @(negedge clk);
    chk("stall_done", 32'(done0), 1);
    chk("stall_level", 32'(lvl0), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_no_dup_read", 32'(read0), 0);
    end

`ifdef ALARM_POLL_IRQ_EN
    chk("irq_sticky", 32'(irq0), 1);
    ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
    chk("irq_ack_clear", 32'(irq0), 0);
    poll0(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    poll0(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rd0 = '0;
    rd0[0] = 1'b1;
    wait_read(0, ok);
    chk("irq_timeout", 32'(ok), 1);
    @(negedge clk);
    ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
    chk("irq_coinc_rise", 32'(rise0), 1);
    chk("irq_coinc_set", 32'(irq0), 1);
    @(negedge clk);
    chk("irq_coinc_hold", 32'(irq0), 1);
`endif
    en0 = 1'b0;

    en1 = 1'b1;
    poll1(1'b1, 1'b1, 1'b0, 1'b0);
    poll1(1'b0, 1'b0, 1'b1, 1'b1);
    nrd = 0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      nrd += int'(read1);
      ndone += int'(done1);
    end
    chk("disabled_reads", 32'(nrd), 0);
    chk("disabled_done", 32'(ndone), 0);
    chk("disabled_level_hold", 32'(lvl1), 0);

    en1 = 1'b1;
    poll1(1'b1, 1'b1, 1'b0, 1'b0);
    wait_read(1, ok);
    chk("rst_req_timeout", 32'(ok), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_req_read", 32'(read1), 0);
    chk("rst_req_addr", 32'(addr1), 0);
    chk("rst_req_level", 32'(lvl1), 0);
    @(negedge clk);
    en1 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
